// File: rtl/matmul_host_sequencer.sv
// -----------------------------------------------------------------------------
// matmul_host_sequencer
//
// Host-side driver/collector for a simple generic matrix multiplier. Takes one
// valid/ready operand stream (A row-major, then B row-major), writes it into the
// multiplier through its a/b write ports, pulses mm_start, captures the M*P
// results into a local C buffer and replays them row-major on a valid/ready
// output stream with an end-of-matrix marker.
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   s_data/s_valid/s_ready operand input stream
//   mm_a_in/addr/wen      A write port towards the multiplier (registered)
//   mm_b_in/addr/wen      B write port towards the multiplier (registered)
//   mm_start              single-cycle start pulse (registered)
//   mm_c_out/mm_c_valid   result stream from the multiplier
//   mm_done               multiplier finished
//   m_data/m_valid/m_ready/m_last  result output stream, m_last on element M*P-1
//   busy                  low only when idle in LOAD_A with nothing loaded
//   err_overflow          sticky: result arrived with the C buffer already full
//   err_short             sticky: mm_done arrived before M*P results were captured
// -----------------------------------------------------------------------------
module matmul_host_sequencer #(
  parameter int M          = 3,
  parameter int N          = 3,
  parameter int P          = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [DATA_WIDTH-1:0]     mm_a_in,
  output logic [$clog2(M*N)-1:0]    mm_a_addr,
  output logic                      mm_a_wen,
  output logic [DATA_WIDTH-1:0]     mm_b_in,
  output logic [$clog2(N*P)-1:0]    mm_b_addr,
  output logic                      mm_b_wen,
  output logic                      mm_start,
  input  logic [2*DATA_WIDTH-1:0]   mm_c_out,
  input  logic                      mm_c_valid,
  input  logic                      mm_done,
  output logic [2*DATA_WIDTH-1:0]   m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_last,
  output logic                      busy,
  output logic                      err_overflow,
  output logic                      err_short
);

  localparam int MN   = M * N;
  localparam int NP   = N * P;
  localparam int MP   = M * P;
  localparam int AW_A = $clog2(MN);
  localparam int AW_B = $clog2(NP);
  localparam int LD_W = (AW_A > AW_B) ? AW_A : AW_B;
  localparam int RD_W = $clog2(MP);
  localparam int C_W  = $clog2(MP + 1);

  localparam logic [LD_W-1:0] A_LAST  = LD_W'(MN - 1);
  localparam logic [LD_W-1:0] B_LAST  = LD_W'(NP - 1);
  localparam logic [RD_W-1:0] RD_LAST = RD_W'(MP - 1);
  localparam logic [C_W-1:0]  C_FULL  = C_W'(MP);

  typedef enum logic [2:0] {
    ST_LOAD_A = 3'd0,
    ST_LOAD_B = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [LD_W-1:0]         ld_cnt_q, ld_cnt_d;
  logic [C_W-1:0]          c_cnt_q, c_cnt_d;
  logic [RD_W-1:0]         rd_cnt_q, rd_cnt_d;
  logic [DATA_WIDTH-1:0]   a_in_q, a_in_d, b_in_q, b_in_d;
  logic [AW_A-1:0]         a_addr_q, a_addr_d;
  logic [AW_B-1:0]         b_addr_q, b_addr_d;
  logic                    a_wen_q, a_wen_d, b_wen_q, b_wen_d;
  logic                    start_q, start_d;
  logic                    err_ovf_q, err_ovf_d, err_short_q, err_short_d;
  logic                    c_store;

  // C buffer is deliberately not reset: a short run drains whatever was left
  // in the uncaptured slots.
  logic [2*DATA_WIDTH-1:0] c_buf_q [MP];

  assign mm_a_in      = a_in_q;
  assign mm_a_addr    = a_addr_q;
  assign mm_a_wen     = a_wen_q;
  assign mm_b_in      = b_in_q;
  assign mm_b_addr    = b_addr_q;
  assign mm_b_wen     = b_wen_q;
  assign mm_start     = start_q;
  assign err_overflow = err_ovf_q;
  assign err_short    = err_short_q;
  assign busy         = !((state_q == ST_LOAD_A) && (ld_cnt_q == '0));

  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    c_cnt_d     = c_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    a_in_d      = a_in_q;
    a_addr_d    = a_addr_q;
    b_in_d      = b_in_q;
    b_addr_d    = b_addr_q;
    a_wen_d     = 1'b0;
    b_wen_d     = 1'b0;
    start_d     = 1'b0;
    err_ovf_d   = err_ovf_q;
    err_short_d = err_short_q;
    c_store     = 1'b0;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    m_data      = '0;
    m_last      = 1'b0;

    case (state_q)
      ST_LOAD_A: begin
        s_ready = 1'b1;
        if (s_valid) begin
          a_in_d   = s_data;
          a_addr_d = ld_cnt_q[AW_A-1:0];
          a_wen_d  = 1'b1;
          if (ld_cnt_q == A_LAST) begin
            ld_cnt_d = '0;
            state_d  = ST_LOAD_B;
          end else begin
            ld_cnt_d = ld_cnt_q + 1'b1;
          end
        end
      end

      ST_LOAD_B: begin
        s_ready = 1'b1;
        if (s_valid) begin
          b_in_d   = s_data;
          b_addr_d = ld_cnt_q[AW_B-1:0];
          b_wen_d  = 1'b1;
          if (ld_cnt_q == B_LAST) begin
            ld_cnt_d = '0;
            state_d  = ST_START;
          end else begin
            ld_cnt_d = ld_cnt_q + 1'b1;
          end
        end
      end

      // One cycle here puts the registered start pulse one cycle after the
      // final B write strobe.
      ST_START: begin
        start_d = 1'b1;
        state_d = ST_WAIT;
      end

      // A result arriving together with mm_done is captured before the
      // short-run check, so c_cnt_d already includes it.
      ST_WAIT: begin
        if (mm_c_valid) begin
          if (c_cnt_q < C_FULL) begin
            c_store = 1'b1;
            c_cnt_d = c_cnt_q + 1'b1;
          end else begin
            err_ovf_d = 1'b1;
          end
        end
        if (mm_done) begin
          state_d = ST_DRAIN;
          if (c_cnt_d < C_FULL) begin
            err_short_d = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        m_valid = 1'b1;
        m_data  = c_buf_q[rd_cnt_q];
        m_last  = (rd_cnt_q == RD_LAST);
        if (m_ready) begin
          if (rd_cnt_q == RD_LAST) begin
            rd_cnt_d = '0;
            c_cnt_d  = '0;
            state_d  = ST_LOAD_A;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_LOAD_A;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD_A;
      ld_cnt_q    <= '0;
      c_cnt_q     <= '0;
      rd_cnt_q    <= '0;
      a_in_q      <= '0;
      a_addr_q    <= '0;
      b_in_q      <= '0;
      b_addr_q    <= '0;
      a_wen_q     <= 1'b0;
      b_wen_q     <= 1'b0;
      start_q     <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_short_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      c_cnt_q     <= c_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      a_in_q      <= a_in_d;
      a_addr_q    <= a_addr_d;
      b_in_q      <= b_in_d;
      b_addr_q    <= b_addr_d;
      a_wen_q     <= a_wen_d;
      b_wen_q     <= b_wen_d;
      start_q     <= start_d;
      err_ovf_q   <= err_ovf_d;
      err_short_q <= err_short_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && c_store) begin
      c_buf_q[c_cnt_q[RD_W-1:0]] <= mm_c_out;
    end
  end

endmodule

// File: tb/tb_matmul_host_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matmul_host_sequencer
//
// Self-checking bench for matmul_host_sequencer (3x3x3, 8-bit operands).
// A behavioural multiplier answers the a/b writes and mm_start; expected
// results come from a plain matrix product of the scenario operands and a
// model of the in-order C buffer that persists across runs.
// -----------------------------------------------------------------------------
module tb_matmul_host_sequencer;

  localparam int MP = 9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  mm_a_in;
  logic [3:0]  mm_a_addr;
  logic        mm_a_wen;
  logic [7:0]  mm_b_in;
  logic [3:0]  mm_b_addr;
  logic        mm_b_wen;
  logic        mm_start;
  logic [15:0] mm_c_out;
  logic        mm_c_valid;
  logic        mm_done;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic        err_overflow;
  logic        err_short;

  matmul_host_sequencer #(.M(3), .N(3), .P(3), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mm_a_in(mm_a_in), .mm_a_addr(mm_a_addr), .mm_a_wen(mm_a_wen),
    .mm_b_in(mm_b_in), .mm_b_addr(mm_b_addr), .mm_b_wen(mm_b_wen),
    .mm_start(mm_start),
    .mm_c_out(mm_c_out), .mm_c_valid(mm_c_valid), .mm_done(mm_done),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .err_overflow(err_overflow), .err_short(err_short)
  );

  always #5 clk = ~clk;

  // Scenario records: operands and multiplier behaviour in, error flags out.
  typedef struct {
    logic [8:0][7:0] a;
    logic [8:0][7:0] b;
    int              n_res;
    int              s_gap;
    int              m_rdy;
    int              c_gap;
    bit              done_with_last;
    bit              exp_short;
    bit              exp_ovf;
  } vec_t;

  vec_t vecs [6];

  int vectors    = 0;
  int miscompares = 0;

  // Reference C buffer: in-order capture, never cleared by reset.
  logic [15:0] ref_buf [MP];
  int          ref_cnt = 0;

  // Monitor / behavioural multiplier state, written only by the monitor.
  logic [7:0] mult_a [9];
  logic [7:0] mult_b [9];
  logic [3:0] a_log_addr [$];
  logic [7:0] a_log_data [$];
  logic [3:0] b_log_addr [$];
  logic [7:0] b_log_data [$];
  int cyc = 0, last_b_cyc = 0, start_cyc = 0, start_n = 0, start_wide = 0;
  logic prev_start = 1'b0;

  // Write port and start monitor, sampled away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (mm_a_wen === 1'b1) begin
      if (int'(mm_a_addr) < 9) mult_a[mm_a_addr] = mm_a_in;
      a_log_addr.push_back(mm_a_addr);
      a_log_data.push_back(mm_a_in);
    end
    if (mm_b_wen === 1'b1) begin
      if (int'(mm_b_addr) < 9) mult_b[mm_b_addr] = mm_b_in;
      b_log_addr.push_back(mm_b_addr);
      b_log_data.push_back(mm_b_in);
      last_b_cyc = cyc;
    end
    if (mm_start === 1'b1) begin
      start_n++;
      start_cyc = cyc;
      if (prev_start) start_wide++;
    end
    prev_start = (mm_start === 1'b1);
  end

  function automatic logic [15:0] matProd(input logic [8:0][7:0] a,
                                          input logic [8:0][7:0] b, input int k);
    int acc = 0;
    for (int t = 0; t < 3; t++)
      acc += int'($signed(a[(k / 3) * 3 + t])) * int'($signed(b[t * 3 + (k % 3)]));
    return acc[15:0];
  endfunction

  function automatic logic [15:0] multOut(input int k);
    logic [8:0][7:0] a, b;
    for (int i = 0; i < 9; i++) begin
      a[i] = mult_a[i];
      b[i] = mult_b[i];
    end
    return matProd(a, b, k);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n   = 1'b1;
    ref_cnt = 0;
  endtask

  task automatic sendStream(input logic [8:0][7:0] a, input logic [8:0][7:0] b, input int gap);
    int guard;
    for (int i = 0; i < 18; i++) begin
      while (int'($urandom_range(0, 99)) < gap) begin
        s_valid = 1'b0;
        tick();
      end
      s_valid = 1'b1;
      s_data  = (i < 9) ? a[i] : b[i - 9];
      guard   = 0;
      while (s_ready !== 1'b1 && guard < 500) begin
        tick();
        guard++;
      end
      if (guard >= 500) checkOutput("s_ready_timeout", 0, 1);
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic waitStart();
    int guard = 0;
    while (mm_start !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) checkOutput("start_timeout", 0, 1);
  endtask

  task automatic captureRef(input logic [15:0] val);
    if (ref_cnt < MP) begin
      ref_buf[ref_cnt] = val;
      ref_cnt++;
    end
  endtask

  task automatic emitResults(input int n, input int gap, input bit dwl, input logic [8:0][15:0] gold);
    for (int k = 0; k < n; k++) begin
      while (int'($urandom_range(0, 99)) < gap) begin
        mm_c_valid = 1'b0;
        tick();
      end
      mm_c_valid = 1'b1;
      mm_c_out   = (k < MP) ? multOut(k) : 16'h7777;
      captureRef((k < MP) ? gold[k] : 16'h7777);
      mm_done    = (dwl && k == n - 1);
      tick();
    end
    mm_c_valid = 1'b0;
    if (!dwl) begin
      mm_done = 1'b1;
      tick();
    end
    mm_done = 1'b0;
  endtask

  task automatic drainAndCheck(input int rdy_pct);
    int          idx = 0, guard = 0;
    bit          stalled = 0;
    logic [15:0] prev = '0;
    while (idx < MP && guard < 2000) begin
      m_ready = (int'($urandom_range(0, 99)) < rdy_pct);
      if (stalled) begin
        checkOutput("stall_valid", m_valid, 1);
        checkOutput("stall_hold", m_data, prev);
      end
      stalled = 0;
      if (m_valid === 1'b1) begin
        if (m_ready) begin
          checkOutput("m_data", m_data, ref_buf[idx]);
          checkOutput("m_last", m_last, (idx == MP - 1));
          idx++;
        end else begin
          stalled = 1;
          prev    = m_data;
        end
      end
      tick();
      guard++;
    end
    m_ready = 1'b0;
    s_valid = 1'b0;
    ref_cnt = 0;
    if (idx < MP) checkOutput("drain_timeout", idx, MP);
  endtask

  task automatic applyStimulus(input int id, input bit do_reset);
    vec_t            v = vecs[id];
    logic [8:0][15:0] gold;
    int a0 = a_log_addr.size(), b0 = b_log_addr.size(), s0 = start_n, w0 = start_wide;
    for (int k = 0; k < MP; k++) gold[k] = matProd(v.a, v.b, k);
    if (do_reset) resetDut();
    checkOutput("idle_s_ready", s_ready, 1);
    sendStream(v.a, v.b, v.s_gap);
    waitStart();
    checkOutput("busy_run", busy, 1);
    checkOutput("no_s_ready_wait", s_ready, 0);
    s_valid = 1'b1;
    s_data  = 8'h55;
    emitResults(v.n_res, v.c_gap, v.done_with_last, gold);
    drainAndCheck(v.m_rdy);
    checkOutput("a_wr_count", a_log_addr.size() - a0, 9);
    checkOutput("b_wr_count", b_log_addr.size() - b0, 9);
    for (int i = 0; i < 9; i++) begin
      if (a0 + i < a_log_addr.size()) begin
        checkOutput("a_addr", a_log_addr[a0 + i], i);
        checkOutput("a_data", a_log_data[a0 + i], v.a[i]);
      end
      if (b0 + i < b_log_addr.size()) begin
        checkOutput("b_addr", b_log_addr[b0 + i], i);
        checkOutput("b_data", b_log_data[b0 + i], v.b[i]);
      end
    end
    checkOutput("start_pulses", start_n - s0, 1);
    checkOutput("start_width", start_wide - w0, 0);
    checkOutput("start_after_b", start_cyc - last_b_cyc, 1);
    checkOutput("err_short", err_short, v.exp_short);
    checkOutput("err_overflow", err_overflow, v.exp_ovf);
    checkOutput("post_s_ready", s_ready, 1);
    checkOutput("post_m_valid", m_valid, 0);
    checkOutput("post_busy", busy, 0);
  endtask

  initial begin
    logic [8:0][15:0] gold2;

    rst_n      = 1'b0;
    s_valid    = 1'b1;
    s_data     = 8'h11;
    mm_c_valid = 1'b1;
    mm_c_out   = 16'h1234;
    mm_done    = 1'b0;
    m_ready    = 1'b0;

    // Scenario table.
    for (int i = 0; i < 9; i++) begin
      vecs[0].a[i] = (i % 4 == 0) ? 8'd1 : 8'd0;
      vecs[0].b[i] = 8'(i + 1);
      vecs[1].a[i] = 8'hFF;
      vecs[1].b[i] = 8'd2;
      vecs[2].a[i] = 8'(i + 1);
      vecs[2].b[i] = 8'(9 - i);
      vecs[3].a[i] = 8'($urandom);
      vecs[3].b[i] = 8'($urandom);
      vecs[4].a[i] = 8'($urandom);
      vecs[4].b[i] = 8'($urandom);
      vecs[5].a[i] = 8'($urandom);
      vecs[5].b[i] = 8'($urandom);
    end
    //                n_res s_gap m_rdy c_gap dwl short ovf
    vecs[0].n_res = 9;  vecs[0].s_gap = 0;  vecs[0].m_rdy = 100; vecs[0].c_gap = 0;
    vecs[1].n_res = 9;  vecs[1].s_gap = 0;  vecs[1].m_rdy = 100; vecs[1].c_gap = 0;
    vecs[2].n_res = 9;  vecs[2].s_gap = 50; vecs[2].m_rdy = 50;  vecs[2].c_gap = 30;
    vecs[3].n_res = 4;  vecs[3].s_gap = 20; vecs[3].m_rdy = 70;  vecs[3].c_gap = 20;
    vecs[4].n_res = 10; vecs[4].s_gap = 20; vecs[4].m_rdy = 70;  vecs[4].c_gap = 20;
    vecs[5].n_res = 9;  vecs[5].s_gap = 30; vecs[5].m_rdy = 60;  vecs[5].c_gap = 20;
    for (int i = 0; i < 6; i++) begin
      vecs[i].done_with_last = (i == 5);
      vecs[i].exp_short      = (i == 3);
      vecs[i].exp_ovf        = (i == 4);
    end

    // Reset with traffic on the inputs.
    tick();
    tick();
    rst_n      = 1'b1;
    s_valid    = 1'b0;
    mm_c_valid = 1'b0;
    checkOutput("rst_s_ready", s_ready, 1);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_a_wen", mm_a_wen, 0);
    checkOutput("rst_b_wen", mm_b_wen, 0);
    checkOutput("rst_start", mm_start, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err_short", err_short, 0);
    checkOutput("rst_err_ovf", err_overflow, 0);
    tick();
    checkOutput("rst_idle_s_ready", s_ready, 1);
    checkOutput("rst_idle_busy", busy, 0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(i, 1'b1);
    end

    // Reset in the middle of WAIT after five captures.
    resetDut();
    for (int k = 0; k < MP; k++) gold2[k] = matProd(vecs[2].a, vecs[2].b, k);
    sendStream(vecs[2].a, vecs[2].b, 0);
    waitStart();
    for (int k = 0; k < 5; k++) begin
      mm_c_valid = 1'b1;
      mm_c_out   = multOut(k);
      captureRef(gold2[k]);
      tick();
    end
    mm_c_valid = 1'b0;
    rst_n      = 1'b0;
    tick();
    rst_n      = 1'b1;
    ref_cnt    = 0;
    checkOutput("midrst_s_ready", s_ready, 1);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_a_wen", mm_a_wen, 0);
    checkOutput("midrst_b_wen", mm_b_wen, 0);
    checkOutput("midrst_start", mm_start, 0);
    checkOutput("midrst_m_valid", m_valid, 0);
    for (int k = 0; k < 3; k++) begin
      mm_c_valid = 1'b1;
      mm_c_out   = 16'hBEEF;
      tick();
    end
    mm_c_valid = 1'b0;
    mm_done    = 1'b1;
    tick();
    mm_done    = 1'b0;
    checkOutput("stale_s_ready", s_ready, 1);
    checkOutput("stale_m_valid", m_valid, 0);
    checkOutput("stale_busy", busy, 0);
    checkOutput("stale_err_short", err_short, 0);
    checkOutput("stale_err_ovf", err_overflow, 0);
    applyStimulus(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matmul_host_sequencer.md
Name: matmul_host_sequencer

Overview:
- Host-side driver and collector for simple_generic_matrix_mult.
- Accepts one valid/ready input stream carrying A (M*N elements, row-major) then B (N*P elements, row-major), and writes them through the multiplier's a/b write ports.
- Pulses mm_start, captures the M*P results from mm_c_out/mm_c_valid into a local C buffer, then replays C row-major on a valid/ready output stream with an end-of-matrix marker.

Parameters:
- M, 3, rows of A and C
- N, 3, columns of A and rows of B
- P, 3, columns of B and C
- DATA_WIDTH, 8, signed operand width; result width is 2*DATA_WIDTH

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- s_data  in  DATA_WIDTH  operand element, signed
- s_valid  in  1  s_data valid
- s_ready  out  1  sequencer accepts s_data
- mm_a_in  out  DATA_WIDTH  A write data to multiplier
- mm_a_addr  out  $clog2(M*N)  A write address
- mm_a_wen  out  1  A write enable
- mm_b_in  out  DATA_WIDTH  B write data
- mm_b_addr  out  $clog2(N*P)  B write address
- mm_b_wen  out  1  B write enable
- mm_start  out  1  start pulse to multiplier
- mm_c_out  in  2*DATA_WIDTH  result element from multiplier
- mm_c_valid  in  1  mm_c_out valid
- mm_done  in  1  multiplier finished
- m_data  out  2*DATA_WIDTH  result element, row-major
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accepts m_data
- m_last  out  1  marks element M*P-1
- busy  out  1  high in every state except LOAD_A with load count 0
- err_overflow  out  1  sticky: mm_c_valid seen when M*P results were already captured
- err_short  out  1  sticky: mm_done seen with fewer than M*P results captured

Behaviour:
- Reset, when rst_n is low at a clock edge:
  - state goes to LOAD_A; all counters are 0.
  - All outputs go to 0, except s_ready, which is 1 in the first cycle after reset.
  - The C buffer contents are not cleared.
  - The sequencer does not reset the multiplier; system reset covers both.
- Input handshake is s_valid && s_ready. Output handshake is m_valid && m_ready.
- LOAD_A:
  - s_ready = 1.
  - On handshake: register mm_a_in = s_data, mm_a_addr = ld_cnt, mm_a_wen = 1 for exactly one cycle (latency 1 cycle from handshake); ld_cnt increments.
  - On the handshake with ld_cnt == M*N-1: ld_cnt returns to 0 and state goes to LOAD_B.
- LOAD_B:
  - Same as LOAD_A, but drives mm_b_* and ends at N*P-1; then state goes to START.
  - s_ready drops to 0 the cycle after the last B handshake.
- START:
  - mm_start = 1 for exactly one cycle, registered.
  - This places start one cycle after the final mm_b_wen, so the last B write lands before the multiplier samples start.
  - State goes to WAIT.
- WAIT:
  - Each cycle with mm_c_valid: if c_cnt < M*P, store C[c_cnt] = mm_c_out and increment c_cnt; otherwise set err_overflow and drop the data.
  - mm_done goes to DRAIN. If the sum of c_cnt and the capture made in this same cycle is less than M*P, set err_short.
  - mm_c_valid and mm_done in the same cycle: capture first, then transition.
  - mm_c_valid and mm_done are ignored in every state other than WAIT.
- DRAIN:
  - m_valid = 1 and m_data = C[rd_cnt].
  - m_data holds stable while m_valid && !m_ready.
  - m_last = (rd_cnt == M*P-1).
  - On handshake rd_cnt increments. The handshake with m_last clears rd_cnt and c_cnt and goes to LOAD_A.
  - Always exactly M*P elements are drained; uncaptured slots present stale buffer data when err_short is set.
- Sticky errors are cleared only by reset.
- Results pass through unmodified; no width change or sign handling beyond capture.
- s_valid while s_ready = 0 is held off with no side effects.
- Reset mid-operation (any state) returns to LOAD_A next cycle with s_ready = 1 and no pending mm_*_wen or mm_start.
- No other states exist; an illegal encoding goes to LOAD_A.

Test Plan:
- Reset: rst_n low for 2 cycles, with s_valid=1 and mm_c_valid=1 -> after release s_ready=1, m_valid=0, mm_a_wen=mm_b_wen=mm_start=0, busy=0, both err flags 0.
- Identity, 3x3: A=I, B=1..9 streamed back-to-back, real multiplier attached -> 9 A writes at addr 0..8, then 9 B writes, then one single-cycle mm_start; m_data = 1..9 in order with m_last only on 9.
- Signed values: A all -1, B all 2 -> every m_data = 16'hFFFA (-6); err_overflow=0, err_short=0.
- Backpressure: random s_valid gaps and m_ready toggling at 50%, A=1..9, B=9..1 -> results match the golden model, with no drop or duplicate, and m_data stable during stalls.
- Errors, using a behavioural multiplier model: mm_done after 4 mm_c_valid -> err_short=1 and 9 elements drained. Separately, 10 mm_c_valid then mm_done -> err_overflow=1, first 9 results kept.
- Reset mid-WAIT after 5 captures, with stale mm_c_valid arriving afterwards -> next cycle state is LOAD_A with s_ready=1; the stale results are ignored, and a fresh full run produces correct C.
